memory_bus: RTL and testbench
=============================

Name: memory_bus

Overview:
- Byte-addressed, multi-width memory port for the Forth core. Serves byte, half-word and word accesses at any byte alignment.
- Storage is BANKS byte-lane synchronous RAMs. Byte k of an access maps to lane (a+k) mod BANKS, row (a+k)/BANKS, little-endian.
- An access that spans two rows runs as a two-phase sequence under a req/ack handshake.
- Replaces the single-width byte memory as the dictionary/data store.

Parameters:
- ASZ, 12, byte-address width; total capacity 2^ASZ bytes.
- BANKS, 4, byte lanes per row; power of two, ≥ 4. Sets the widest access (word = 4 bytes).
- WSZ, 8, bits per lane (byte width).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = write, 0 = read; sampled with req.
- sz  in  2  access size: 0 = byte, 1 = half (2 bytes), 2 = word (4 bytes), 3 = reserved.
- sx  in  1  sign-extend read data (byte/half reads only).
- a  in  ASZ  byte address, any alignment.
- i  in  4*WSZ  write data; little-endian, low bytes used for byte/half.
- o  out  4*WSZ  read data; zero- or sign-extended.
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualifies ack; 1 = reserved size rejected.
- busy  out  1  access in progress; req ignored.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - ack=0, err=0, busy=0, o=0.
  - RAM contents are not cleared.
  - Reset overrides every other input in that cycle.
- Acceptance: req=1 && busy=0 at edge ending cycle N. a, we, sz, sx and i are latched; later input changes are ignored.
- Byte count: n = 1/2/4 for sz = 0/1/2. Byte addresses are a..a+n-1, each taken mod 2^ASZ, so accesses wrap from the top of memory to address 0.
- Crossing: the access is two-row when (a mod BANKS) + n > BANKS; otherwise it is single-row.
- FSM states: IDLE, P1 (first row), P2 (second row), DONE (ack cycle).
  - IDLE --accept--> P1.
  - P1 --crossing--> P2; otherwise P1 --> DONE.
  - P2 --> DONE.
  - DONE --> IDLE.
- busy=1 in every state except IDLE, including the ack cycle. A new req is accepted no earlier than the cycle after ack.
- Write timing:
  - Only the targeted lanes of the addressed row are written; other lanes are untouched.
  - Single-row write: ack in cycle N+2.
  - Two-row write: first-row lanes are written at the end of P1, second-row lanes at the end of P2; ack in cycle N+3.
  - o is unchanged by writes.
- Read timing:
  - Lane RAMs read synchronously. Bytes are rotated into order and assembled into o, registered.
  - o and ack are updated together: ack in N+2 for single-row, N+3 for two-row.
  - o holds its value until the next read ack.
- Extension:
  - sx=0: upper bytes are zero.
  - sx=1: bit 8n-1 is replicated into the upper bits.
  - sz=2 ignores sx.
- Reserved size (sz=3):
  - No RAM access.
  - FSM goes IDLE → DONE; ack=1 and err=1 in N+1; o unchanged.
  - err=0 on every other ack.
- Reset mid-operation: any row not yet written stays unwritten, ack is never issued, and busy=0 from the next cycle. A partially completed two-row write leaves its first row written.
- req while busy: ignored, with no queueing.

Test Plan (ASZ=8, BANKS=4):
- Word write 0x11223344 at a=0x10, then word read at 0x10:
  - Write ack in N+2, with busy high in N+1 and N+2.
  - Read returns o=0x11223344 in N+2.
  - Byte read at 0x11 with sx=0 gives o=0x00000033.
- Write byte 0x80 at 0x20, then byte read at 0x20:
  - sx=1 gives o=0xFFFFFF80.
  - sx=0 gives o=0x00000080.
  - Half read at 0x20 with sx=1 over a stored 0x0080 gives 0x00000080.
- Crossing word write 0xAABBCCDD at 0x0E:
  - ack in N+3.
  - Byte reads at 0x0E, 0x0F, 0x10, 0x11 give DD, CC, BB, AA.
  - Half read at 0x0F gives 0x0000BBCC with ack in N+3.
  - Lanes at 0x0D and 0x12 keep their prior values.
- Wrap: word write 0x01020304 at 0xFE:
  - Bytes at 0xFE, 0xFF, 0x00, 0x01 = 04, 03, 02, 01.
  - Word read at 0xFE returns 0x01020304.
- Handshake and error:
  - req held high for 6 cycles gives exactly one ack per accepted access; the next accept is the cycle after ack.
  - sz=3 write gives ack=1, err=1 in N+1, with memory unchanged (verified by readback).
- Reset mid-write: crossing write 0xAABBCCDD at 0x1E, with rst_n=0 during cycle N+2 (P2):
  - No ack; busy=0 afterwards; o=0.
  - 0x1E and 0x1F hold DD and CC; 0x20 and 0x21 are unchanged.

Source files
------------

// File: rtl/memory_bus.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus
// Brief    : Byte-addressed byte/half/word memory port built from BANKS
//            byte-lane synchronous RAMs. Accesses that straddle two rows run
//            as a two-phase sequence; completion is a one-cycle ack pulse.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus #(
    parameter int ASZ   = 12,
    parameter int BANKS = 4,
    parameter int WSZ   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       sz,
    input  logic             sx,
    input  logic [ASZ-1:0]   a,
    input  logic [4*WSZ-1:0] i,
    output logic [4*WSZ-1:0] o,
    output logic             ack,
    output logic             err,
    output logic             busy
);
    localparam int c_LB   = $clog2(BANKS);
    localparam int c_RW   = ASZ - c_LB;
    localparam int c_ROWS = 1 << c_RW;
    localparam int c_DW   = 4 * WSZ;
    localparam logic [c_LB:0] c_BANKS = (c_LB+1)'(BANKS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_P1   = 2'd1;
    localparam logic [1:0] c_ST_P2   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;

    // Request latched at acceptance
    logic [ASZ-1:0]  r_a;
    logic            r_we;
    logic [1:0]      r_sz;
    logic            r_sx;
    logic [c_DW-1:0] r_i;
    logic            r_err;

    logic            w_idle;
    logic            w_accept;
    logic            w_cross;
    logic            w_fin;

    // Access geometry: taken straight from the inputs while idle (so the
    // first-row read can start in the accept cycle), from the latch otherwise.
    logic [c_LB-1:0] w_lane0;
    logic [c_RW-1:0] w_row0;
    logic [1:0]      w_sz;
    logic [c_LB:0]   w_n;

    logic [WSZ-1:0]  w_ibyte [4];
    logic [WSZ-1:0]  w_q     [BANKS];
    logic [c_DW-1:0] w_raw;
    logic [c_DW-1:0] w_rd;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = req && w_idle;
    assign w_lane0  = w_idle ? a[c_LB-1:0]   : r_a[c_LB-1:0];
    assign w_row0   = w_idle ? a[ASZ-1:c_LB] : r_a[ASZ-1:c_LB];
    assign w_sz     = w_idle ? sz : r_sz;

    // Byte count of the access in flight (reserved size never touches RAM)
    always_comb begin
        w_n = (c_LB+1)'(4);
        case (w_sz)
            2'd0:    w_n = (c_LB+1)'(1);
            2'd1:    w_n = (c_LB+1)'(2);
            default: w_n = (c_LB+1)'(4);
        endcase
    end

    assign w_cross = (({1'b0, w_lane0} + w_n) > c_BANKS);

    // Read data is final at the end of the last row phase of a read
    assign w_fin = !r_we && (((r_state == c_ST_P1) && !w_cross) || (r_state == c_ST_P2));

    for (genvar b = 0; b < 4; b++) begin : g_ibyte
        assign w_ibyte[b] = r_i[b*WSZ +: WSZ];
    end

    // Each byte of an access lands in a distinct lane. Lanes below the start
    // lane belong to the following row, which only happens on a crossing.
    for (genvar l = 0; l < BANKS; l++) begin : g_lane
        logic [WSZ-1:0]  r_mem [c_ROWS];
        logic [WSZ-1:0]  r_q;
        logic [c_LB-1:0] w_k;
        logic            w_tgt;
        logic            w_hi;
        logic            w_re;
        logic            w_wr;
        logic [c_RW-1:0] w_row;

        assign w_k   = c_LB'(l) - w_lane0;
        assign w_tgt = ({1'b0, w_k} < w_n) && (w_sz != 2'd3);
        assign w_hi  = (c_LB'(l) < w_lane0);
        assign w_row = w_row0 + c_RW'(w_hi);
        assign w_re  = w_tgt && ((w_accept && !we && !w_hi) ||
                                 ((r_state == c_ST_P1) && !r_we && w_hi));
        assign w_wr  = rst_n && r_we && w_tgt &&
                       (((r_state == c_ST_P1) && !w_hi) || ((r_state == c_ST_P2) && w_hi));

        // Single-port lane RAM; read data holds until the lane is read again
        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[w_row] <= w_ibyte[w_k[1:0]];
            end
            if (w_re) begin
                r_q <= r_mem[w_row];
            end
        end

        assign w_q[l] = r_q;
    end

    // Rotate lane outputs into access order and apply zero/sign extension
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 4; k++) begin
            w_raw[k*WSZ +: WSZ] = w_q[r_a[c_LB-1:0] + c_LB'(k)];
        end
        case (r_sz)
            2'd0:    w_rd = {{(c_DW-WSZ){r_sx & w_raw[WSZ-1]}}, w_raw[WSZ-1:0]};
            2'd1:    w_rd = {{(c_DW-2*WSZ){r_sx & w_raw[2*WSZ-1]}}, w_raw[2*WSZ-1:0]};
            default: w_rd = w_raw;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: reserved size skips the row phases entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next = (sz == 2'd3) ? c_ST_DONE : c_ST_P1;
            c_ST_P1:   w_next = w_cross ? c_ST_P2 : c_ST_DONE;
            c_ST_P2:   w_next = c_ST_DONE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Handshake outputs; busy covers the ack cycle as well
    always_comb begin
        ack  = (r_state == c_ST_DONE);
        err  = ack && r_err;
        busy = !w_idle;
    end

    // Request latch and registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_we  <= 1'b0;
            r_sz  <= 2'd0;
            r_sx  <= 1'b0;
            r_i   <= '0;
            r_err <= 1'b0;
            o     <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_we  <= we;
                r_sz  <= sz;
                r_sx  <= sx;
                r_i   <= i;
                r_err <= (sz == 2'd3);
            end
            if (w_fin) begin
                o <= w_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus
// Brief    : Self-checking bench for memory_bus (ASZ=8, BANKS=4, WSZ=8):
//            directed vector table, handshake/reset sequences and random
//            accesses against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus;
    localparam int ASZ   = 8;
    localparam int BANKS = 4;
    localparam int WSZ   = 8;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic           we;
    logic [1:0]     sz;
    logic           sx;
    logic [ASZ-1:0] a;
    logic [31:0]    i;
    logic [31:0]    o;
    logic           ack;
    logic           err;
    logic           busy;

    int total;
    int bad;

    logic [7:0]  m_mem [256];
    logic [31:0] m_o;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] eo;
        int          lat;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    memory_bus #(.ASZ(ASZ), .BANKS(BANKS), .WSZ(WSZ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .sz(sz), .sx(sx),
        .a(a), .i(i), .o(o), .ack(ack), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic x,
                                input logic [7:0] ad, input logic [31:0] d,
                                input logic [31:0] eo, input int lat, input logic e);
        vec_t v;
        v.we = w; v.sz = s; v.sx = x; v.a = ad; v.d = d; v.eo = eo; v.lat = lat; v.err = e;
        return v;
    endfunction

    // Reference: cycles from accept to ack
    function automatic int m_lat(input logic [1:0] s, input logic [7:0] ad);
        int n;
        if (s == 2'd3) return 1;
        n = 1 << s;
        return ((int'(ad[1:0]) + n) > 4) ? 3 : 2;
    endfunction

    // Reference: little-endian gather with wrap, then extension
    function automatic logic [31:0] m_read(input logic [1:0] s, input logic x, input logic [7:0] ad);
        int n;
        logic [31:0] v;
        n = 1 << s;
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(m_mem[8'(ad + k)]) << (8 * k));
        if (s < 2'd2 && x && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One complete access starting in the current (idle) cycle; inputs are
    // scrambled after acceptance to confirm they are latched.
    task automatic xfer(input logic twe, input logic [1:0] tsz, input logic tsx,
                        input logic [7:0] ta, input logic [31:0] td, input string tag,
                        output logic [31:0] g_o, output int g_lat, output logic g_err);
        int          e_lat;
        logic [31:0] e_o;
        logic        e_err;
        logic        busy_ok;
        e_lat = m_lat(tsz, ta);
        e_err = (tsz == 2'd3);
        e_o   = (!twe && tsz != 2'd3) ? m_read(tsz, tsx, ta) : m_o;
        req = 1'b1; we = twe; sz = tsz; sx = tsx; a = ta; i = td;
        g_lat = -1; g_o = 32'h0; g_err = 1'b0; busy_ok = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (!busy) busy_ok = 1'b0;
            if (ack) begin
                g_lat = c; g_o = o; g_err = err;
                break;
            end
            req = 1'($urandom); we = 1'($urandom); sz = 2'($urandom);
            sx = 1'($urandom); a = 8'($urandom); i = $urandom;
        end
        req = 1'b0; a = 8'($urandom); i = $urandom;
        check($sformatf("%s.lat", tag), g_lat, e_lat);
        check($sformatf("%s.err", tag), g_err, e_err);
        check($sformatf("%s.o", tag), g_o, e_o);
        check($sformatf("%s.busy", tag), busy_ok, 1'b1);
        @(posedge clk); #1;
        check($sformatf("%s.idle", tag), {busy, ack}, 2'b00);
        if (tsz != 2'd3) begin
            if (twe) begin
                for (int k = 0; k < (1 << tsz); k++) m_mem[8'(ta + k)] = td[8*k +: 8];
            end else begin
                m_o = e_o;
            end
        end
    endtask

    initial begin
        logic [31:0] g_o;
        int          g_lat;
        logic        g_err;
        logic [31:0] w;
        logic [8:0]  busy_v;
        logic [8:0]  ack_v;
        int          acks;
        int          sel;
        logic [1:0]  rs;

        total = 0; bad = 0;
        for (int k = 0; k < 256; k++) m_mem[k] = 8'h00;
        m_o = 32'h0;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; sz = 2'd0; sx = 1'b0; a = '0; i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ack", ack, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.o", o, 32'h0);
        rst_n = 1'b1;

        // Known background: byte at x holds x ^ 0x5A
        for (int j = 0; j < 64; j++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(4 * j + b) ^ 8'h5A;
            xfer(1'b1, 2'd2, 1'b0, 8'(4 * j), w, "init", g_o, g_lat, g_err);
        end

        //                 we    sz    sx    a      data           exp o         lat err
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 8'h10, 32'h11223344, 32'h00000000, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h11223344, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h11, 32'h0,        32'h00000033, 2, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 8'h20, 32'h00000000, 32'h00000033, 2, 1'b0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h20, 32'h00000080, 32'h00000033, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 8'h20, 32'h0,        32'hFFFFFF80, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h20, 32'h0,        32'h00000080, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 8'h20, 32'h0,        32'h00000080, 2, 1'b0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 8'h0E, 32'hAABBCCDD, 32'h00000080, 3, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h0E, 32'h0,        32'h000000DD, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h0F, 32'h0,        32'h000000CC, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        32'h000000BB, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h11, 32'h0,        32'h000000AA, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 8'h0F, 32'h0,        32'h0000BBCC, 3, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h0D, 32'h0,        32'h00000057, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h12, 32'h0,        32'h00000022, 2, 1'b0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 8'hFE, 32'h01020304, 32'h00000022, 3, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'hFE, 32'h0,        32'h00000004, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'hFF, 32'h0,        32'h00000003, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h00, 32'h0,        32'h00000002, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h01, 32'h0,        32'h00000001, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 8'hFE, 32'h0,        32'h01020304, 3, 1'b0));
        tbl.push_back(mk(1'b1, 2'd3, 1'b0, 8'h10, 32'hDEADBEEF, 32'h01020304, 1, 1'b1));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h1122AABB, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b1, 8'h13, 32'h0,        32'h1122AABB, 1, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 8'h0E, 32'h0,        32'hFFFFCCDD, 2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b1, 8'h0C, 32'h0,        32'hCCDD5756, 2, 1'b0));

        for (int t = 0; t < tbl.size(); t++) begin
            xfer(tbl[t].we, tbl[t].sz, tbl[t].sx, tbl[t].a, tbl[t].d,
                 $sformatf("vec%0d.model", t), g_o, g_lat, g_err);
            check($sformatf("vec%0d.o", t), g_o, tbl[t].eo);
            check($sformatf("vec%0d.lat", t), g_lat, tbl[t].lat);
            check($sformatf("vec%0d.err", t), g_err, tbl[t].err);
        end

        // req held for six cycles: two accepts, two acks, one cycle apart
        req = 1'b1; we = 1'b0; sz = 2'd2; sx = 1'b0; a = 8'h10; i = 32'h0;
        busy_v = '0; ack_v = '0;
        for (int c = 0; c < 9; c++) begin
            busy_v[c] = busy;
            ack_v[c]  = ack;
            if (c == 5) w = o;
            if (c == 6) req = 1'b0;
            @(posedge clk); #1;
        end
        req = 1'b0;
        check("hs.busy", busy_v, 9'b000110110);
        check("hs.ack", ack_v, 9'b000100100);
        check("hs.o", w, m_read(2'd2, 1'b0, 8'h10));
        m_o = m_read(2'd2, 1'b0, 8'h10);

        // Reset during the second row of a crossing write
        acks = 0;
        req = 1'b1; we = 1'b1; sz = 2'd2; sx = 1'b0; a = 8'h1E; i = 32'hAABBCCDD;
        @(posedge clk); #1;
        req = 1'b0;
        acks += int'(ack);
        @(posedge clk); #1;
        acks += int'(ack);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst.busy", busy, 1'b0);
        check("mrst.o", o, 32'h0);
        for (int c = 0; c < 3; c++) begin
            acks += int'(ack);
            @(posedge clk); #1;
        end
        check("mrst.acks", acks, 0);
        m_mem[8'h1E] = 8'hDD;
        m_mem[8'h1F] = 8'hCC;
        m_o = 32'h0;
        xfer(1'b0, 2'd0, 1'b0, 8'h1E, 32'h0, "mrst.1E", g_o, g_lat, g_err);
        check("mrst.1E.const", g_o, 32'h000000DD);
        xfer(1'b0, 2'd0, 1'b0, 8'h1F, 32'h0, "mrst.1F", g_o, g_lat, g_err);
        check("mrst.1F.const", g_o, 32'h000000CC);
        xfer(1'b0, 2'd0, 1'b0, 8'h20, 32'h0, "mrst.20", g_o, g_lat, g_err);
        check("mrst.20.const", g_o, 32'h00000080);
        xfer(1'b0, 2'd0, 1'b0, 8'h21, 32'h0, "mrst.21", g_o, g_lat, g_err);
        check("mrst.21.const", g_o, 32'h00000000);

        // Random traffic against the model
        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(0, 2)) begin
                req = 1'b0; a = 8'($urandom); sz = 2'($urandom);
                @(posedge clk); #1;
            end
            sel = $urandom_range(0, 9);
            rs  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            xfer(1'($urandom), rs, 1'($urandom), 8'($urandom), $urandom,
                 $sformatf("rnd%0d", r), g_o, g_lat, g_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
